// File: rtl/tx_scheduler.sv
// Byte FIFO and frame sequencer in front of tx_frontend: queues bus writes,
// issues one transmit pulse per byte, waits for done and inserts an idle gap.
module tx_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               cr_gap_i,
  input  logic                     wr_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     flush_i,
  input  logic                     ovf_clr_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic                     transmit_o,
  output logic [7:0]               dr_o,
  input  logic                     done_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  dr_q, dr_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];

  logic [AW:0] count;
  logic        full, empty, pop, push, ovf_set;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Write side is a bare strobe with no back-pressure: wr_i is taken when
  // there is room (or a pop frees a slot this cycle), otherwise dropped and
  // flagged in ovf_o. Writes coinciding with flush_i are silently discarded.
  assign push    = wr_i && !flush_i && (!full || pop);
  assign ovf_set = wr_i && !flush_i && full && !pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dr_d    = dr_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !flush_i) begin
          pop     = 1'b1;
          dr_d    = mem_q[rd_ptr_q[AW-1:0]];
          state_d = LOAD;
        end
      end
      LOAD: state_d = BUSY;
      BUSY: begin
        if (done_i) begin
          if (cr_gap_i == 8'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cr_gap_i - 8'd1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (flush_i)  rd_ptr_d = wr_ptr_q;
    else if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    ovf_d = ovf_q;
    if (ovf_set)        ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      dr_q     <= 8'h00;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dr_q     <= dr_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count;
  assign busy_o     = (state_q != IDLE);
  assign ovf_o      = ovf_q;
  assign transmit_o = (state_q == LOAD);
  assign dr_o       = dr_q;

endmodule
